// File: rtl/byte_mem_pkg.sv
// Shared types and helpers for the byte-addressed memory controller:
// FSM state encoding, misaligned merge and full-width range check.
package byte_mem_pkg;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_e;

    // Widest access the helpers support; wider WORD_BYTES needs this raised.
    localparam int MAX_WORD_BYTES = 16;
    localparam int MAX_DW         = 8 * MAX_WORD_BYTES;

    // Result byte k is byte (off+k) of the little-endian pair {w1, w0}.
    function automatic logic [MAX_DW-1:0] byte_mem_merge(
        input logic [MAX_DW-1:0] w0,
        input logic [MAX_DW-1:0] w1,
        input logic [3:0]        off,
        input logic [4:0]        wb
    );
        logic [2*MAX_DW-1:0] pair;
        pair = ({{MAX_DW{1'b0}}, w1} << {wb, 3'b000}) | {{MAX_DW{1'b0}}, w0};
        pair = pair >> {off, 3'b000};
        return pair[MAX_DW-1:0];
    endfunction

    // One extra bit on the sum keeps addresses near the top of the space from wrapping.
    function automatic logic byte_mem_in_range(
        input logic [63:0] a,
        input logic [63:0] wb,
        input logic [63:0] depth
    );
        return ({1'b0, a} + {1'b0, wb}) <= {1'b0, depth};
    endfunction

endpackage

// File: rtl/byte_mem_array.sv
// Single-port synchronous word array with per-byte write enables.
// Bytes 0..INIT_RAMP-1 power up holding their own index, all others zero.
module byte_mem_array #(
    parameter int WORDS      = 256,
    parameter int WORD_BYTES = 4,
    parameter int INIT_RAMP  = 16,
    localparam int DW        = 8 * WORD_BYTES,
    localparam int AW        = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [WORD_BYTES-1:0] be_i,
    input  logic [DW-1:0]         wdata_i,
    output logic [DW-1:0]         rdata_o
);
    typedef logic [WORDS-1:0][DW-1:0] mem_t;

    function automatic mem_t ramp_init();
        mem_t m;
        for (int w = 0; w < WORDS; w++) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                m[w][8*b +: 8] = (w * WORD_BYTES + b < INIT_RAMP) ? 8'(w * WORD_BYTES + b) : 8'h00;
            end
        end
        return m;
    endfunction

    // Power-up contents only; reset deliberately leaves the array alone.
    mem_t          mem_q = ramp_init();
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < WORD_BYTES; b++) begin
                    if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/byte_mem_ctrl.sv
// Byte-addressed memory front end: valid/ready request, misaligned split into two
// word accesses, one-cycle response pulse. Define BYTE_MEM_WRITE_EN for the write path.
module byte_mem_ctrl
    import byte_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WORD_BYTES  = 4,
    parameter int ADDR_W      = 32,
    parameter int INIT_RAMP   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_W-1:0]       req_addr_i,
    input  logic                    req_we_i,
    input  logic [WORD_BYTES-1:0]   req_be_i,
    input  logic [8*WORD_BYTES-1:0] req_wdata_i,
    output logic                    rsp_valid_o,
    output logic [8*WORD_BYTES-1:0] rsp_rdata_o,
    output logic                    rsp_err_o
);
    localparam int WORDS = DEPTH_BYTES / WORD_BYTES;
    localparam int DW    = 8 * WORD_BYTES;
    localparam int AW    = $clog2(WORDS);
    localparam int OW    = $clog2(WORD_BYTES);

`ifdef BYTE_MEM_WRITE_EN
    localparam logic WRITE_EN = 1'b1;
`else
    localparam logic WRITE_EN = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [AW-1:0]         word_q;
    logic [OW-1:0]         off_q;
    logic                  we_q, err_q;
    logic [WORD_BYTES-1:0] be_q;
    logic [DW-1:0]         wdata_q, w0_q;

    logic                    accept, req_err, req_mis;
    logic                    arr_en, arr_we;
    logic [AW-1:0]           arr_addr;
    logic [WORD_BYTES-1:0]   arr_be;
    logic [DW-1:0]           arr_wdata, arr_rdata, merged;
    logic [2*DW-1:0]         wd_sh;
    logic [2*WORD_BYTES-1:0] be_sh;
    logic [MAX_DW-1:0]       merged_full;

    assign req_ready_o = (state_q == IDLE) && !rst;
    assign accept      = req_valid_i && req_ready_o;
    assign req_err     = !byte_mem_in_range(64'(req_addr_i), 64'(WORD_BYTES), 64'(DEPTH_BYTES))
                         || (req_we_i && !WRITE_EN);
    assign req_mis     = req_addr_i[OW-1:0] != '0;

    // Misaligned writes: shifting data and enables by the offset splits them across both words.
    assign wd_sh = {{DW{1'b0}}, wdata_q} << {off_q, 3'b000};
    assign be_sh = {{WORD_BYTES{1'b0}}, be_q} << off_q;

    always_comb begin
        state_d   = state_q;
        arr_en    = 1'b0;
        arr_we    = we_q && WRITE_EN;
        arr_addr  = word_q;
        arr_be    = be_sh[WORD_BYTES-1:0];
        arr_wdata = wd_sh[DW-1:0];
        case (state_q)
            IDLE: begin
                arr_en    = accept && !req_err && !req_mis;
                arr_we    = req_we_i && WRITE_EN;
                arr_addr  = req_addr_i[AW+OW-1:OW];
                arr_be    = req_be_i;
                arr_wdata = req_wdata_i;
                if (accept) state_d = (req_err || !req_mis) ? RESP : LOW;
            end
            LOW: begin
                arr_en  = !rst;
                state_d = HIGH;
            end
            HIGH: begin
                arr_en    = !rst;
                arr_addr  = word_q + AW'(1);
                arr_be    = be_sh[2*WORD_BYTES-1:WORD_BYTES];
                arr_wdata = wd_sh[2*DW-1:DW];
                state_d   = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_q  <= req_addr_i[AW+OW-1:OW];
                off_q   <= req_addr_i[OW-1:0];
                we_q    <= req_we_i;
                be_q    <= req_be_i;
                wdata_q <= req_wdata_i;
                err_q   <= req_err;
            end
            if (state_q == HIGH) w0_q <= arr_rdata;
        end
    end

    byte_mem_array #(
        .WORDS      (WORDS),
        .WORD_BYTES (WORD_BYTES),
        .INIT_RAMP  (INIT_RAMP)
    ) u_array (
        .clk     (clk),
        .en_i    (arr_en),
        .we_i    (arr_we),
        .addr_i  (arr_addr),
        .be_i    (arr_be),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    // In RESP the array output holds the high word of a split access, w0_q the low word.
    assign merged_full = byte_mem_merge(MAX_DW'(w0_q), MAX_DW'(arr_rdata), 4'(off_q), 5'(WORD_BYTES));
    assign merged      = (off_q != '0) ? merged_full[DW-1:0] : arr_rdata;

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_err_o   = (state_q == RESP) && err_q;
    assign rsp_rdata_o = ((state_q == RESP) && !err_q && !we_q) ? merged : '0;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Self-checking bench for byte_mem_ctrl: directed scenarios plus a randomized mix
// checked against a flat byte-array reference model.
module tb_byte_mem_ctrl;
    localparam int DEPTH = 1024;
    localparam int WB    = 4;
`ifdef BYTE_MEM_WRITE_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata;
    logic [3:0]  req_be = '0;
    logic        rsp_valid, rsp_err;

    int          n_checks = 0, n_fail = 0;
    int unsigned cyc = 0, acc_cyc = 0;
    logic [7:0]  ref_mem [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    byte_mem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_we_i    (req_we),
        .req_be_i    (req_be),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    // Reference: flat byte array, accesses computed byte by byte from the address.
    task automatic ref_access(input logic [31:0] a, input logic we, input logic [3:0] be,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output logic er, output int lat);
        logic [63:0] end_a;
        end_a = {32'h0, a} + 64'(WB);
        rd  = '0;
        er  = (end_a > 64'(DEPTH)) || (we && !WEN);
        lat = (er || (a % WB) == 0) ? 1 : 3;
        if (!er) begin
            for (int k = 0; k < WB; k++) begin
                if (we) begin
                    if (be[k]) ref_mem[a + k] = wd[8*k +: 8];
                end else begin
                    rd[8*k +: 8] = ref_mem[a + k];
                end
            end
        end
    endtask

    // Issues one request, returns response fields, latency and whether the pulse was single-cycle.
    task automatic do_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output logic single, output logic ok);
        int guard = 0;
        rd = 'x; er = 'x; lat = 0; single = 1'b0; ok = 1'b1;
        while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        if (!req_ready) begin ok = 1'b0; return; end
        req_valid = 1'b1; req_addr = a; req_we = we; req_be = be; req_wdata = wd;
        @(posedge clk); #1;
        acc_cyc   = cyc;
        req_valid = 1'b0; req_addr = $urandom; req_we = 1'($urandom);
        req_be    = 4'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) begin ok = 1'b0; return; end
        rd = rsp_rdata; er = rsp_err;
        @(posedge clk); #1;
        single = !rsp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_addr = 32'd4; req_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: valid=%b ready=%b, want 0 0", rsp_valid, req_ready);
        end
        n_checks++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp: rdata=%h err=%b, want 0 0", rsp_rdata, rsp_err);
        end
        rst = 1'b0; req_valid = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_with_valid: rsp_valid=%b want 0", rsp_valid); end
    endtask

    task automatic test_aligned_read();
        logic [31:0] rd; logic er, single, ok; int lat;
        do_req(32'd4, 1'b0, 4'h0, 32'h0, rd, er, lat, single, ok);
        n_checks++;
        if (!ok || !single) begin n_fail++; $display("FAIL aligned_handshake: ok=%b single=%b want 1 1", ok, single); end
        n_checks++;
        if (rd !== 32'h07060504 || er !== 1'b0) begin
            n_fail++; $display("FAIL aligned_data: rdata=%h err=%b want 07060504 0", rd, er);
        end
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL aligned_latency: got %0d want 1", lat); end
    endtask

    task automatic test_misaligned_read();
        logic [31:0] rd; logic er, single, ok; int lat;
        do_req(32'd13, 1'b0, 4'h0, 32'h0, rd, er, lat, single, ok);
        n_checks++;
        if (!ok || !single) begin n_fail++; $display("FAIL misaligned_handshake: ok=%b single=%b want 1 1", ok, single); end
        n_checks++;
        if (rd !== 32'h000F0E0D || er !== 1'b0) begin
            n_fail++; $display("FAIL misaligned_data: rdata=%h err=%b want 000f0e0d 0", rd, er);
        end
        n_checks++;
        if (lat != 3) begin n_fail++; $display("FAIL misaligned_latency: got %0d want 3", lat); end
    endtask

    task automatic test_boundary();
        logic [31:0] addrs [4] = '{32'd1020, 32'd1021, 32'hFFFF_FFFF, 32'd1019};
        logic [31:0] exp_rd [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
        logic        exp_er [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int          exp_lat [4] = '{1, 1, 1, 3};
        logic [31:0] rd; logic er, single, ok; int lat;
        for (int i = 0; i < 4; i++) begin
            do_req(addrs[i], 1'b0, 4'h0, 32'h0, rd, er, lat, single, ok);
            n_checks++;
            if (!ok || !single || rd !== exp_rd[i] || er !== exp_er[i] || lat != exp_lat[i]) begin
                n_fail++;
                $display("FAIL boundary_%h: ok=%b single=%b rdata=%h err=%b lat=%0d want 1 1 %h %b %0d",
                         addrs[i], ok, single, rd, er, lat, exp_rd[i], exp_er[i], exp_lat[i]);
            end
        end
    endtask

    task automatic test_write();
        logic [31:0] rd, erd; logic er, eer, single, ok; int lat, elat;
        ref_access(32'd2, 1'b1, 4'b1011, 32'hAABBCCDD, erd, eer, elat);
        do_req(32'd2, 1'b1, 4'b1011, 32'hAABBCCDD, rd, er, lat, single, ok);
        n_checks++;
        if (!ok || !single || rd !== 32'h0 || er !== eer || lat != elat) begin
            n_fail++; $display("FAIL write_rsp: ok=%b rdata=%h err=%b lat=%0d want 1 0 %b %0d", ok, rd, er, lat, eer, elat);
        end
        do_req(32'd0, 1'b0, 4'h0, 32'h0, rd, er, lat, single, ok);
        n_checks++;
`ifdef BYTE_MEM_WRITE_EN
        if (rd !== 32'hCCDD0100 || er !== 1'b0) begin
            n_fail++; $display("FAIL write_readback0: rdata=%h err=%b want ccdd0100 0", rd, er);
        end
`else
        if (rd !== 32'h03020100 || er !== 1'b0) begin
            n_fail++; $display("FAIL rom_readback0: rdata=%h err=%b want 03020100 0", rd, er);
        end
`endif
        ref_access(32'd4, 1'b0, 4'h0, 32'h0, erd, eer, elat);
        do_req(32'd4, 1'b0, 4'h0, 32'h0, rd, er, lat, single, ok);
        n_checks++;
        if (rd !== erd || er !== eer) begin
            n_fail++; $display("FAIL write_readback4: rdata=%h err=%b want %h %b", rd, er, erd, eer);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er, single, ok; int lat;
        logic seen = 1'b0;
        req_valid = 1'b1; req_addr = 32'd13; req_we = 1'b0;
        @(posedge clk); #1;        // accepted, now in LOW
        req_valid = 1'b0;
        @(posedge clk); #1;        // now in HIGH
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", req_ready); end
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp: rsp_valid seen=%b want 0", seen); end
        do_req(32'd13, 1'b0, 4'h0, 32'h0, rd, er, lat, single, ok);
        n_checks++;
        if (!ok || rd !== {ref_mem[16], ref_mem[15], ref_mem[14], ref_mem[13]} || er !== 1'b0) begin
            n_fail++; $display("FAIL abort_recover: ok=%b rdata=%h err=%b", ok, rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd; logic er, eer, single, ok; int lat, elat;
        int unsigned prev;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, DEPTH / WB - 1)) * WB;
            ref_access(a, 1'b0, 4'h0, 32'h0, erd, eer, elat);
            do_req(a, 1'b0, 4'h0, 32'h0, rd, er, lat, single, ok);
            n_checks++;
            if (!ok || rd !== erd || er !== eer || lat != 1 || (i > 0 && acc_cyc - prev != 2)) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: ok=%b rdata=%h err=%b lat=%0d gap=%0d want %h %b 1 2",
                         i, ok, rd, er, lat, acc_cyc - prev, erd, eer);
            end
            prev = acc_cyc;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, erd; logic we, er, eer, single, ok; logic [3:0] be; int lat, elat;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(DEPTH - 8, DEPTH + 2));
                default: a = 32'($urandom_range(0, DEPTH - 1));
            endcase
            we = ($urandom_range(0, 2) == 0);
            be = 4'($urandom); wd = $urandom;
            ref_access(a, we, be, wd, erd, eer, elat);
            do_req(a, we, be, wd, rd, er, lat, single, ok);
            n_checks++;
            if (!ok || !single || rd !== erd || er !== eer || lat != elat) begin
                n_fail++;
                $display("FAIL random_%0d addr=%h we=%b be=%b: ok=%b single=%b rdata=%h err=%b lat=%0d want %h %b %0d",
                         i, a, we, be, ok, single, rd, er, lat, erd, eer, elat);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i < 16) ? 8'(i) : 8'h00;
        test_reset();
        test_aligned_read();
        test_misaligned_read();
        test_boundary();
        test_write();
        test_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
